// File: rtl/toeplitz_hash_serializer.sv
// Captures a finished Toeplitz hash on the rising edge of write_en and streams it
// MSW-first as WORD_W-bit words. Optional trailing XOR checksum word: SER_CHECKSUM_EN.
module toeplitz_hash_serializer #(
  parameter int DATA_W    = 3072,
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = DATA_W / WORD_W,
  parameter int CNT_W     = 7
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              write_en,
  input  logic [DATA_W-1:0] final_result,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic [15:0]       frame_cnt,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
`ifdef SER_CHECKSUM_EN
  localparam logic [1:0] ST_CSUM = 2'd2;
`endif

  // Handshake: a word moves on a rising clk_in edge where out_valid & out_ready;
  // out_data/out_valid/out_last stay constant until that edge, and out_ready
  // is ignored while out_valid is low.

  logic [1:0]        state;
  logic [DATA_W-1:0] shadow;
  logic [CNT_W-1:0]  idx;
  logic              we_q;
  logic              armed;
  logic              start;
  logic              xfer;
  logic              last_word;
  logic [WORD_W-1:0] cur_word;
`ifdef SER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
`endif

  // armed stays low until write_en has been seen low once after reset, so a
  // strobe held high across reset release is not mistaken for a new edge.
  assign start     = write_en & ~we_q & armed;
  assign busy      = (state != ST_IDLE);
  assign out_valid = busy;
  assign xfer      = out_valid & out_ready;
  assign last_word = (idx == CNT_W'(NUM_WORDS - 1));
  assign state_dbg = state;

  // The shadow register shifts left after each transfer, so the next word is
  // always at the top and no wide word mux is needed.
  assign cur_word  = shadow[DATA_W-1 -: WORD_W];

`ifdef SER_CHECKSUM_EN
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (state == ST_SEND) begin
      out_data = cur_word;
    end else if (state == ST_CSUM) begin
      out_data = csum;
      out_last = 1'b1;
    end
  end
`else
  assign out_data = busy ? cur_word : '0;
  assign out_last = busy & last_word;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      idx       <= '0;
      we_q      <= 1'b0;
      armed     <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= 16'd0;
`ifdef SER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      we_q  <= write_en;
      armed <= armed | ~write_en;
      done  <= 1'b0;

      // A new result while busy is dropped; set takes priority over clear.
      if (start && busy) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            shadow <= final_result;
            idx    <= '0;
            state  <= ST_SEND;
`ifdef SER_CHECKSUM_EN
            csum   <= '0;
`endif
          end
        end

        ST_SEND: begin
          if (xfer) begin
`ifdef SER_CHECKSUM_EN
            csum <= csum ^ cur_word;
`endif
            if (last_word) begin
              idx <= '0;
`ifdef SER_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state     <= ST_IDLE;
              done      <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
`endif
            end else begin
              idx    <= idx + CNT_W'(1);
              shadow <= {shadow[DATA_W-WORD_W-1:0], {WORD_W{1'b0}}};
            end
          end
        end

`ifdef SER_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer) begin
            state     <= ST_IDLE;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/toeplitz_hash_serializer.md
Name: toeplitz_hash_serializer

Overview:
- Downstream of the Toeplitz row-accumulation stage. Captures the finished 3072-bit hash when that stage raises its write strobe.
- Streams the hash out as 32-bit words over a valid/ready interface toward the output FIFO/host link.
- Provides busy/done status, frame counting and overrun detection, so no hash is silently lost or torn.

Parameters:
- DATA_W, 3072, width of hash result input; must be an integer multiple of WORD_W.
- WORD_W, 32, width of each output word.
- NUM_WORDS, DATA_W/WORD_W (96), words per frame; derived, do not override.
- CNT_W, 7, width of word index counter; must satisfy 2^CNT_W >= NUM_WORDS+1.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_en  input  1  result-ready strobe from accumulation stage; may stay high for several cycles.
- final_result  input  DATA_W  hash value; valid in the first cycle write_en is high.
- out_data  output  WORD_W  current output word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the word.
- out_last  output  1  high with the final word of a frame.
- busy  output  1  frame capture or streaming in progress.
- done  output  1  one-cycle pulse after the final word transfers.
- overrun  output  1  sticky; a new result arrived while busy.
- ovr_clr  input  1  synchronous clear of overrun.
- frame_cnt  output  16  count of completed frames; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (async, rst high): state=IDLE, shadow register=0, word index=0, write_en_q=0.
  - Outputs: out_data=0, out_valid=0, out_last=0, busy=0, done=0, overrun=0, frame_cnt=0.
- Start detection is rising-edge only: start = write_en & ~write_en_q.
  - write_en_q registers write_en every cycle.
  - A multi-cycle-high write_en yields exactly one capture.
- States: IDLE, SEND, CSUM (CSUM exists only with the optional feature).
- IDLE: when start is seen at a clock edge:
  - Capture final_result into the shadow register; index<=0; state<=SEND.
  - busy=1 and out_valid=1 from the next cycle, so latency from strobe to first valid word is 1 cycle.
- Word order: word k = shadow[DATA_W-1-k*WORD_W -: WORD_W]. Word 0 is bits [3071:3040]; word 95 is bits [31:0].
- SEND transfer rule:
  - A transfer occurs at an edge with out_valid & out_ready; index then increments.
  - out_data and out_valid are held stable while out_ready is low.
  - out_ready high while out_valid is low has no effect.
- out_last=1 while index==NUM_WORDS-1 (or while in CSUM when that feature is enabled).
- On transfer of the last word:
  - out_valid<=0, busy<=0, done<=1 for one cycle, frame_cnt<=frame_cnt+1, state<=IDLE.
  - Back-to-back frames are allowed: a start seen in the cycle right after done is accepted.
- Overrun: a start seen while busy=1 sets overrun<=1.
  - The new value is dropped; the frame in flight is unaffected.
  - ovr_clr clears overrun. If ovr_clr and a new overrun coincide, set wins.
- A start seen on the same edge as the last word's transfer counts as an overrun, because busy is still 1 at that edge.
- Reset mid-frame aborts immediately: all outputs return to reset values. A write_en still high after rst deasserts is not a rising edge and starts no capture.
- Throughput: with out_ready held at 1, a frame takes exactly NUM_WORDS cycles of out_valid.

Optional Feature:
- Macro SER_CHECKSUM_EN.
- When defined:
  - A running XOR of all transferred data words is accumulated, cleared at capture.
  - After word NUM_WORDS-1 transfers, state<=CSUM and out_data=checksum with out_valid=1, out_last=1. out_last is 0 on word 95.
  - Its transfer ends the frame (done, frame_cnt++). Frame length is NUM_WORDS+1.
- When undefined: no CSUM state and no accumulator. Frame is NUM_WORDS words with out_last on word 95.

Test Plan:
- Reset then final_result=3072'h1 with 1-cycle write_en, out_ready=1 -> out_valid high next cycle; 95 words 0x00000000 then 0x00000001 with out_last; done pulse; frame_cnt=1.
- final_result with word k = k (word 0 = 0x00000000 … word 95 = 0x0000005F), write_en held high 2 cycles -> exactly one frame, words 0..95 in order, no overrun.
- Same frame, out_ready toggling 1,0,0,1 repeating -> out_data stable across stalls; all 96 words delivered exactly once; done only after word 95 transfers.
- Second write_en rising edge at word 10 of a frame -> overrun=1; current frame completes unchanged; second value never emitted; ovr_clr pulse -> overrun=0.
- rst asserted at word 50 -> all outputs 0 immediately; next write_en edge after release starts a fresh frame from word 0.
- SER_CHECKSUM_EN defined, all words = 0xA5A5A5A5 -> 96 data words with out_last low, then checksum 0x00000000 with out_last=1 (96 equal words XOR to 0); frame length 97.
